bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter, the decoding counterpart of the combinational binary-to-BCD stage in the board designs. It takes DIGITS packed BCD digits, for example from switch banks or a BCD entry counter, and produces the equivalent unsigned binary value. It uses an iterative reverse double-dabble: one shift-right plus a subtract-3 correction per clock. A start/done handshake lets the top level feed the result to arithmetic or counter-load logic.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_to_bin_seq_if.sv | 16 +
 rtl/bcd_to_bin_seq_sub3.sv | 13 +
 rtl/bcd_to_bin_seq.sv | 140 ++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Optional feature macro used by the converter: BCD2BIN_RANGE_CHECK_EN.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] CORR_THRESH = 4'd8;
  localparam logic [3:0] CORR_VAL    = 4'd3;

  // Minimum binary width able to hold 10^digits - 1.
  function automatic int clog2_dec(input int digits);
    int max_val;
    int width;
    max_val = 1;
    for (int i = 0; i < digits; i++) begin
      max_val = max_val * 10;
    end
    max_val = max_val - 1;
    width = 0;
    while ((1 << width) <= max_val) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle of the BCD-to-binary converter.
// master drives the request, slave (the converter) returns the result.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output start, bcd_in, input bin_out, busy, done, err);
  modport slave  (input start, bcd_in, output bin_out, busy, done, err);
endinterface

// File: rtl/bcd_to_bin_seq_sub3.sv
// Per-nibble correction of the reverse double-dabble: the inverse of the
// add-3 cell used by the binary-to-BCD direction.
module sub3
  import bcd_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  // A nibble that reached 8 or more after the shift gets 3 taken off.
  always_comb nib_out = (nib_in >= CORR_THRESH) ? (nib_in - CORR_VAL) : nib_in;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (iterative reverse double-dabble).
// One right shift plus per-nibble subtract-3 correction per clock; the load
// of a new request is merged into the first shift.
// Optional macro BCD2BIN_RANGE_CHECK_EN: reject requests holding a nibble > 9
// through the ERR state and raise a sticky err flag. Without it err is 0.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = clog2_dec(DIGITS)
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_to_bin_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [BIN_W-1:0]  bin_out_q, bin_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SR_W-1:0]   step_in, step_sh, step_out;

  // In IDLE the iteration works on the freshly loaded word, otherwise on the register.
  always_comb step_in = (state_q == IDLE) ? {bus.bcd_in, {BIN_W{1'b0}}} : sr_q;

  assign step_sh = step_in >> 1;
  assign step_out[BIN_W-1:0] = step_sh[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    sub3 u_sub3 (
      .nib_in  (step_sh[BIN_W + 4*g +: 4]),
      .nib_out (step_out[BIN_W + 4*g +: 4])
    );
  end

  assign cnt_next = cnt_q + 1'b1;

`ifdef BCD2BIN_RANGE_CHECK_EN
  logic digits_ok;
  logic err_q, err_d;

  // A request is valid only if every nibble is a decimal digit.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > BCD_MAX) digits_ok = 1'b0;
    end
  end

  // err is raised by the error path and held until a valid request is accepted.
  always_comb begin
    err_d = err_q;
    if (state_q == ERR) err_d = 1'b1;
    else if ((state_q == IDLE) && bus.start && digits_ok) err_d = 1'b0;
  end

  // Sticky error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Next-state, datapath and registered-output logic of the converter FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    bin_out_d = bin_out_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef BCD2BIN_RANGE_CHECK_EN
        if (bus.start && !digits_ok) begin
          state_d = ERR;
        end else
`endif
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = step_out;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        sr_d   = step_out;
        cnt_d  = cnt_next;
        busy_d = 1'b1;
        if (cnt_next == CNT_LAST) state_d = FINISH;
      end
      FINISH: begin
        bin_out_d = sr_q[BIN_W-1:0];
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      bin_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      bin_out_q <= bin_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.bin_out = bin_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: a 3-digit and a 4-digit instance,
// directed cases plus random valid digits checked against a decimal model.
// Error-path cases run only when BCD2BIN_RANGE_CHECK_EN is defined.
module tb_bcd_to_bin_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus3 ();
  bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus4 ();

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Decimal value of packed BCD digits, most significant nibble first.
  function automatic int bcdValue(input logic [15:0] bcd, input int digits);
    int v;
    v = 0;
    for (int i = digits - 1; i >= 0; i--) begin
      v = v * 10 + int'(bcd[4*i +: 4]);
    end
    return v;
  endfunction

  function automatic logic [15:0] randomBcd(input int digits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic sample(input int which, output logic [31:0] bin, output logic busy,
                        output logic done, output logic err);
    if (which == 4) begin
      bin = 32'(bus4.bin_out); busy = bus4.busy; done = bus4.done; err = bus4.err;
    end else begin
      bin = 32'(bus3.bin_out); busy = bus3.busy; done = bus3.done; err = bus3.err;
    end
  endtask

  // One-cycle start pulse; returns #1 after the accepting edge.
  task automatic applyStimulus(input int which, input logic [15:0] bcd);
    if (which == 4) begin
      bus4.start = 1'b1; bus4.bcd_in = bcd;
    end else begin
      bus3.start = 1'b1; bus3.bcd_in = bcd[11:0];
    end
    @(posedge clk); #1;
    bus3.start = 1'b0;
    bus4.start = 1'b0;
  endtask

  // Full conversion with latency, busy length, done pulse and result checks.
  task automatic convert(input int which, input logic [15:0] bcd, input string tag);
    int binw, expv, busyCycles, donePulses;
    logic [31:0] bo;
    logic bu, dn, er;
    binw = (which == 4) ? 14 : 10;
    expv = bcdValue(bcd, which);
    applyStimulus(which, bcd);
    busyCycles = 0;
    donePulses = 0;
    for (int e = 0; e < binw; e++) begin
      sample(which, bo, bu, dn, er);
      if (bu) busyCycles++;
      if (dn) donePulses++;
      @(posedge clk); #1;
    end
    sample(which, bo, bu, dn, er);
    checkOutput({tag, ".bin"}, bo, 32'(expv));
    checkOutput({tag, ".done"}, 32'(dn), 32'd1);
    checkOutput({tag, ".busy_end"}, 32'(bu), 32'd0);
    checkOutput({tag, ".err"}, 32'(er), 32'd0);
    checkOutput({tag, ".busy_cycles"}, 32'(busyCycles), 32'(binw));
    checkOutput({tag, ".early_done"}, 32'(donePulses), 32'd0);
    @(posedge clk); #1;
    sample(which, bo, bu, dn, er);
    checkOutput({tag, ".done_fall"}, 32'(dn), 32'd0);
    checkOutput({tag, ".bin_hold"}, bo, 32'(expv));
  endtask

  initial begin
    logic [31:0] bo;
    logic bu, dn, er;
    logic [15:0] rb;
    int donePulses;

    $display("[TB] start");
    rst_n = 1'b0;
    bus3.start = 1'b0; bus3.bcd_in = '0;
    bus4.start = 1'b0; bus4.bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    sample(3, bo, bu, dn, er);
    checkOutput("reset.bin3", bo, 32'd0);
    checkOutput("reset.busy3", 32'(bu), 32'd0);
    checkOutput("reset.done3", 32'(dn), 32'd0);
    checkOutput("reset.err3", 32'(er), 32'd0);
    sample(4, bo, bu, dn, er);
    checkOutput("reset.bin4", bo, 32'd0);
    checkOutput("reset.done4", 32'(dn), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    convert(3, 16'h0255, "c255");
    convert(3, 16'h0999, "c999");
    convert(3, 16'h0000, "c000");

`ifdef BCD2BIN_RANGE_CHECK_EN
    convert(3, 16'h0321, "pre_err");
    applyStimulus(3, 16'h01A3);
    sample(3, bo, bu, dn, er);
    checkOutput("err.edge0_done", 32'(dn), 32'd0);
    checkOutput("err.edge0_busy", 32'(bu), 32'd0);
    @(posedge clk); #1;
    sample(3, bo, bu, dn, er);
    checkOutput("err.done", 32'(dn), 32'd1);
    checkOutput("err.err", 32'(er), 32'd1);
    checkOutput("err.bin_kept", bo, 32'd321);
    @(posedge clk); #1;
    sample(3, bo, bu, dn, er);
    checkOutput("err.done_fall", 32'(dn), 32'd0);
    checkOutput("err.sticky", 32'(er), 32'd1);
    convert(3, 16'h0123, "after_err");
`endif

    // Second request during an active conversion must be ignored.
    applyStimulus(3, 16'h0042);
    donePulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus3.done) donePulses++;
    end
    bus3.start = 1'b1; bus3.bcd_in = 12'h777;
    for (int e = 3; e <= 9; e++) begin
      @(posedge clk); #1;
      if (bus3.done) donePulses++;
    end
    bus3.start = 1'b0;
    @(posedge clk); #1;
    sample(3, bo, bu, dn, er);
    if (dn) donePulses++;
    checkOutput("busyreq.bin", bo, 32'd42);
    checkOutput("busyreq.done", 32'(dn), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      if (bus3.done) donePulses++;
    end
    checkOutput("busyreq.no_restart", 32'(bus3.busy), 32'd0);
    checkOutput("busyreq.done_once", 32'(donePulses), 32'd1);

    // Asynchronous reset in the middle of a conversion.
    applyStimulus(3, 16'h0500);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sample(3, bo, bu, dn, er);
    checkOutput("midrst.bin", bo, 32'd0);
    checkOutput("midrst.busy", 32'(bu), 32'd0);
    checkOutput("midrst.done", 32'(dn), 32'd0);
    checkOutput("midrst.err", 32'(er), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midrst.idle", 32'(bus3.busy), 32'd0);
    @(posedge clk); #1;
    convert(3, 16'h0500, "c500");

    // start held high: the next request is taken right after done.
    bus3.start = 1'b1; bus3.bcd_in = 12'h314;
    repeat (11) @(posedge clk);
    #1;
    checkOutput("held.first_bin", 32'(bus3.bin_out), 32'd314);
    checkOutput("held.first_done", 32'(bus3.done), 32'd1);
    bus3.bcd_in = 12'h867;
    @(posedge clk); #1;
    checkOutput("held.reaccept_busy", 32'(bus3.busy), 32'd1);
    bus3.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("held.second_bin", 32'(bus3.bin_out), 32'd867);
    checkOutput("held.second_done", 32'(bus3.done), 32'd1);
    @(posedge clk); #1;

    for (int n = 0; n < 8; n++) begin
      rb = randomBcd(3);
      convert(3, rb, $sformatf("rand3_%0d_%03h", n, rb[11:0]));
    end

    convert(4, 16'h9999, "c9999");
    for (int n = 0; n < 3; n++) begin
      rb = randomBcd(4);
      convert(4, rb, $sformatf("rand4_%0d_%04h", n, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
